matvec_engine: RTL and testbench



---
 rtl/matvec_pkg.sv | 16 +
 rtl/matvec_if.sv | 33 +++
 rtl/matvec_mac.sv | 36 +++
 rtl/matvec_engine.sv | 122 ++++++++++++
 tb/tb_matvec_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/matvec_pkg.sv
// Shared constants for the matrix-vector engine, its controller and the bench.
package matvec_pkg;

    // Default geometry: 4x4 matrix of signed 8-bit elements.
    localparam int unsigned DefaultN = 4;
    localparam int unsigned DefaultW = 8;

    // One-hot engine state, also exported on state_out for debug.
    typedef logic [3:0] state_t;

    localparam state_t StIdle  = 4'b0001;
    localparam state_t StRun   = 4'b0010;
    localparam state_t StDrain = 4'b0100;
    localparam state_t StDone  = 4'b1000;

endpackage

// File: rtl/matvec_if.sv
// Multiply handshake plus matrix-memory read port between controller/ROM and engine.
interface matvec_if
    import matvec_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned W     = DefaultW,
    parameter int unsigned ACC_W = 2 * W + $clog2(N),
    parameter int unsigned AW    = $clog2(N * N)
) ();

    logic                 start_mult;
    logic [N*W-1:0]       v_in;
    logic [AW-1:0]        a_addr;
    logic                 a_rd;
    logic [W-1:0]         a_data;
    logic [N*ACC_W-1:0]   y_out;
    logic                 mul_done;
    logic                 busy;
    state_t               state_out;

    // Controller side: issues requests and supplies matrix data.
    modport master (
        output start_mult, v_in, a_data,
        input  a_addr, a_rd, y_out, mul_done, busy, state_out
    );

    // Engine side.
    modport slave (
        input  start_mult, v_in, a_data,
        output a_addr, a_rd, y_out, mul_done, busy, state_out
    );

endinterface

// File: rtl/matvec_mac.sv
// Signed multiply-accumulate with row-end clear; the accumulator lives here.
module matvec_mac #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             row_end,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] sum
);

    logic signed [2*W-1:0] prod;
    logic [ACC_W-1:0]      acc_q;

    // Full-precision signed product, sign-extended into the accumulator width.
    always_comb begin
        prod = $signed(a) * $signed(b);
        sum  = acc_q + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
    end

    // Accumulate within a row; restart from zero once the row's result is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= row_end ? '0 : sum;
        end
    end

endmodule

// File: rtl/matvec_engine.sv
// Sequential signed y = A*v; A streamed from a 1-cycle-latency ROM, row-major.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned W     = DefaultW,
    parameter int unsigned ACC_W = 2 * W + $clog2(N),
    parameter int unsigned AW    = $clog2(N * N)
) (
    input logic     clk,
    input logic     reset,
    matvec_if.slave bus
);

    localparam int unsigned CW = $clog2(N);

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, col_q;
    // Pipeline copies of the issued coordinates, aligned with returning a_data.
    logic              vld_p_q;
    logic [CW-1:0]     row_p_q, col_p_q;
    logic [N*W-1:0]    v_q;
    logic [N*ACC_W-1:0] y_q;

    logic              start_acc;
    logic              last_issue;
    logic              row_end;
    logic [W-1:0]      v_elem;
    logic [ACC_W-1:0]  sum;

    // Decode handshake and pipeline conditions.
    always_comb begin
        start_acc  = (state_q == StIdle) && bus.start_mult;
        last_issue = (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));
        row_end    = (col_p_q == CW'(N - 1));
        v_elem     = v_q[W*int'(col_p_q) +: W];
    end

    // Next-state logic; unknown encodings recover to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start_mult) state_d = StRun;
            StRun:   if (last_issue) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Address counters, vector capture and the one-stage read pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q   <= '0;
            col_q   <= '0;
            vld_p_q <= 1'b0;
            row_p_q <= '0;
            col_p_q <= '0;
            v_q     <= '0;
        end else begin
            vld_p_q <= 1'b0;
            if (start_acc) begin
                v_q   <= bus.v_in;
                row_q <= '0;
                col_q <= '0;
            end else if (state_q == StRun) begin
                vld_p_q <= 1'b1;
                row_p_q <= row_q;
                col_p_q <= col_q;
                if (col_q == CW'(N - 1)) begin
                    col_q <= '0;
                    row_q <= last_issue ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    matvec_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_acc),
        .en      (vld_p_q),
        .row_end (row_end),
        .a       (bus.a_data),
        .b       (v_elem),
        .sum     (sum)
    );

    // Result rows are written once per row and otherwise held for the controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q <= '0;
        end else if (vld_p_q && row_end) begin
            y_q[ACC_W*int'(row_p_q) +: ACC_W] <= sum;
        end
    end

    // Outputs decoded from state and counters.
    always_comb begin
        bus.a_rd      = (state_q == StRun);
        bus.a_addr    = AW'(row_q) * AW'(N) + AW'(col_q);
        bus.mul_done  = (state_q == StDone);
        bus.busy      = (state_q == StRun) || (state_q == StDrain) || (state_q == StDone);
        bus.state_out = state_q;
        bus.y_out     = y_q;
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed and randomised checks of matvec_engine against hand values and a small model.
module tb_matvec_engine;
    import matvec_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned ACC_W = 2 * W + $clog2(N);
    localparam int unsigned AW    = $clog2(N * N);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    matvec_if #(.N(N), .W(W)) bus ();

    matvec_engine #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] rom [N*N];
    logic signed [W-1:0] vv  [N];

    // Synchronous ROM, one cycle read latency.
    always_ff @(posedge clk) bus.a_data <= rom[bus.a_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint y_elem(input int i);
        logic signed [ACC_W-1:0] t;
        t = bus.y_out[i*ACC_W +: ACC_W];
        return longint'(t);
    endfunction

    function automatic longint model_y(input int i);
        longint s = 0;
        for (int j = 0; j < N; j++) s += longint'(rom[i*N+j]) * longint'(vv[j]);
        return s;
    endfunction

    task automatic set_v(input int a, input int b, input int c, input int d);
        vv[0] = W'(a); vv[1] = W'(b); vv[2] = W'(c); vv[3] = W'(d);
        for (int i = 0; i < N; i++) bus.v_in[i*W +: W] = vv[i];
    endtask

    task automatic fill_rom(input int ident, input int val);
        for (int i = 0; i < N * N; i++)
            rom[i] = (ident != 0) ? ((i / N == i % N) ? W'(1) : W'(0)) : W'(val);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the done cycle
    // (or after 45 cycles when watching for a spurious restart).
    task automatic run_op(input int extra_at, output int done_cyc, output int done_cnt,
                          output bit addr_ok, output logic [N*ACC_W-1:0] y_c1);
        done_cyc = 0;
        done_cnt = 0;
        addr_ok  = 1'b1;
        y_c1     = '0;
        bus.start_mult = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            bus.start_mult = (cyc == extra_at);
            if (cyc == extra_at) bus.v_in = ~bus.v_in;
            if (cyc == 1) y_c1 = bus.y_out;
            if (cyc <= N * N && (bus.a_rd !== 1'b1 || bus.a_addr !== AW'(cyc - 1)))
                addr_ok = 1'b0;
            if (cyc == N * N + 1 && bus.a_rd !== 1'b0) addr_ok = 1'b0;
            if (bus.mul_done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && extra_at == 0) break;
        end
    endtask

    int                 dc, dn, dc2, dn2, cnt;
    bit                 ok;
    logic [N*ACC_W-1:0] yc1, y_prev;

    initial begin
        bus.start_mult = 1'b0;
        bus.v_in       = '0;
        fill_rom(0, 0);
        set_v(0, 0, 0, 0);

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_a_rd", longint'(bus.a_rd), 0);
        check("rst_a_addr", longint'(bus.a_addr), 0);
        check("rst_mul_done", longint'(bus.mul_done), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_state", longint'(bus.state_out), longint'(StIdle));
        for (int i = 0; i < N; i++) check("rst_y", y_elem(i), 0);
        reset = 1'b1;
        @(negedge clk);

        // Identity matrix.
        fill_rom(1, 0);
        set_v(1, -2, 3, -4);
        run_op(0, dc, dn, ok, yc1);
        check("ident_done_cyc", dc, 18);
        check("ident_addr_seq", longint'(ok), 1);
        check("ident_busy", longint'(bus.busy), 1);
        check("ident_y0", y_elem(0), 1);
        check("ident_y1", y_elem(1), -2);
        check("ident_y2", y_elem(2), 3);
        check("ident_y3", y_elem(3), -4);
        y_prev = bus.y_out;

        // Back-to-back: start in the first IDLE cycle after DONE.
        @(negedge clk);
        check("b2b_done_low", longint'(bus.mul_done), 0);
        check("b2b_state_idle", longint'(bus.state_out), longint'(StIdle));
        check("b2b_y_held_idle", longint'(bus.y_out == y_prev), 1);
        set_v(-1, 7, 0, 100);
        run_op(0, dc2, dn2, ok, yc1);
        check("b2b_y_held_run", longint'(yc1 == y_prev), 1);
        // One IDLE cycle plus 18 cycles of the second operation.
        check("b2b_gap", dc2 + 1, N * N + 3);
        check("b2b_y0", y_elem(0), -1);
        check("b2b_y1", y_elem(1), 7);
        check("b2b_y2", y_elem(2), 0);
        check("b2b_y3", y_elem(3), 100);
        @(negedge clk);

        // Extra start in cycle 5 (with a changed vector) must be ignored.
        set_v(5, 6, -7, 8);
        run_op(5, dc, dn, ok, yc1);
        check("ign_done_cyc", dc, 18);
        check("ign_done_cnt", dn, 1);
        check("ign_y0", y_elem(0), 5);
        check("ign_y1", y_elem(1), 6);
        check("ign_y2", y_elem(2), -7);
        check("ign_y3", y_elem(3), 8);

        // Most negative operands everywhere.
        fill_rom(0, -128);
        set_v(-128, -128, -128, -128);
        run_op(0, dc, dn, ok, yc1);
        check("ext_done_cyc", dc, 18);
        for (int i = 0; i < N; i++) check("ext_y", y_elem(i), 65536);
        @(negedge clk);

        // Reset asserted in cycle 9 of an operation.
        fill_rom(1, 0);
        set_v(9, 9, 9, 9);
        bus.start_mult = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            bus.start_mult = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("mrst_a_rd", longint'(bus.a_rd), 0);
        check("mrst_a_addr", longint'(bus.a_addr), 0);
        check("mrst_mul_done", longint'(bus.mul_done), 0);
        check("mrst_busy", longint'(bus.busy), 0);
        check("mrst_state", longint'(bus.state_out), longint'(StIdle));
        for (int i = 0; i < N; i++) check("mrst_y", y_elem(i), 0);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.mul_done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        reset = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.mul_done === 1'b1) cnt++;
        end
        check("mrst_no_done", cnt, 0);
        fill_rom(0, 1);
        set_v(2, 2, 2, 2);
        run_op(0, dc, dn, ok, yc1);
        check("mrst_done_cyc", dc, 18);
        check("mrst_addr_seq", longint'(ok), 1);
        for (int i = 0; i < N; i++) check("mrst_y_after", y_elem(i), 8);
        @(negedge clk);

        // Random matrices and vectors against the reference model.
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N * N; i++) rom[i] = W'($urandom);
            set_v(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
            run_op(0, dc, dn, ok, yc1);
            check("rnd_done_cyc", dc, 18);
            check("rnd_addr_seq", longint'(ok), 1);
            for (int i = 0; i < N; i++) check("rnd_y", y_elem(i), model_y(i));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
